// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO fed by a UART receiver's data/rdy handshake, with a sticky overrun flag.
// Optional `RX_FIFO_WATERMARK_EN adds a thresh input and a registered level_irq output.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_rdy_clr,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
`ifdef RX_FIFO_WATERMARK_EN
    input  logic [DEPTH_LOG2:0]   thresh,
    output logic                  level_irq,
`endif
    input  logic                  ovr_clr
);

    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  rx_rdy_clr_reg;
    logic                  overrun_reg;
    logic                  take;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // The receiver still shows rdy during the clr cycle, so that cycle never counts as a new byte.
    assign take = rx_rdy & ~rx_rdy_clr_reg;
    assign pop  = rd_en & ~empty;
    assign push = take & (~full | pop);
    assign drop = take & full & ~pop;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            rx_rdy_clr_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            rx_rdy_clr_reg <= take;
            count_reg      <= count_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // A fresh drop outranks a same-cycle clear so no overrun goes unreported.
            if (drop)
                overrun_reg <= 1'b1;
            else if (ovr_clr)
                overrun_reg <= 1'b0;
        end
    end

    // Storage is intentionally left out of reset; only the pointers define validity.
    always_ff @(posedge clk_50m) begin
        if (push)
            mem[wr_ptr_reg] <= rx_data;
    end

`ifdef RX_FIFO_WATERMARK_EN
    logic level_irq_reg;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)
            level_irq_reg <= 1'b0;
        else
            level_irq_reg <= (thresh != '0) && (count_next >= thresh);
    end

    assign level_irq = level_irq_reg;
`endif

    assign rx_rdy_clr = rx_rdy_clr_reg;
    assign count      = count_reg;
    assign overrun    = overrun_reg;
    assign empty      = (count_reg == '0);
    assign full       = (count_reg == DEPTH_CNT);
    assign rd_data    = empty ? 8'h00 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus scoreboarded sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic                clk_50m = 1'b0;
    logic                rst_n   = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_rdy  = 1'b0;
    logic                rx_rdy_clr;
    logic                rd_en   = 1'b0;
    logic [7:0]          rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                ovr_clr = 1'b0;
`ifdef RX_FIFO_WATERMARK_EN
    logic [DEPTH_LOG2:0] thresh = '0;
    logic                level_irq;
`endif

    int         tests   = 0;
    int         failed  = 0;
    int         m_count = 0;
    int         max_cnt = 0;
    logic [7:0] q[$];

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       rd;
        logic       oclr;
        logic       e_clr;
        logic       e_empty;
        logic       e_full;
        logic       e_ovr;
        logic [4:0] e_count;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [8];

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
`ifdef RX_FIFO_WATERMARK_EN
        .thresh     (thresh),
        .level_irq  (level_irq),
`endif
        .ovr_clr    (ovr_clr)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50m);
        #1;
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    // Receiver model: hold rdy until rdy_clr is seen, drop it one cycle later.
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic store;
        n     = 0;
        store = (m_count < DEPTH);
        rx_data = b;
        rx_rdy  = 1'b1;
        cyc();
        while (!rx_rdy_clr && n < 8) begin
            cyc();
            n++;
        end
        chk($sformatf("take_latency_%0h", b), n, 0);
        if (store) begin
            q.push_back(b);
            m_count++;
        end
        chk($sformatf("count_after_take_%0h", b), count, m_count);
        if (!store) chk($sformatf("overrun_set_%0h", b), overrun, 1);
        cyc();
        chk($sformatf("rdy_clr_width_%0h", b), rx_rdy_clr, 0);
        rx_rdy = 1'b0;
    endtask

    task automatic read_byte();
        logic [7:0] e;
        if (q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL read_underflow: got empty scoreboard required an entry");
            return;
        end
        e = q.pop_front();
        chk($sformatf("rd_data_%0h", e), rd_data, e);
        chk("not_empty_before_pop", empty, 0);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        m_count--;
        chk("count_after_pop", count, m_count);
    endtask

    task automatic drain();
        while (q.size() > 0) read_byte();
        chk("drained_empty", empty, 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA5};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00};
        vecs[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'h5A};
        vecs[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00};
        vecs[5] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'h77};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00};

        #25;
        chk("reset_state", {rx_rdy_clr, empty, full, overrun, count, rd_data},
            {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00});
        @(negedge clk_50m);
        rst_n = 1'b1;
        cyc();

        // Single byte, empty push+pop, re-asserted rdy, rd_en while empty
        for (int i = 0; i < 8; i++) begin
            rx_rdy  = vecs[i].rdy;
            rx_data = vecs[i].data;
            rd_en   = vecs[i].rd;
            ovr_clr = vecs[i].oclr;
            cyc();
            chk($sformatf("vec%0d", i), {rx_rdy_clr, empty, full, overrun, count, rd_data},
                {vecs[i].e_clr, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovr,
                 vecs[i].e_count, vecs[i].e_rd});
        end
        rx_rdy = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
        cyc();

        // Fill, overrun, drain, clear
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        chk("fill_full", {full, count}, {1'b1, 5'd16});
        send_byte(8'h10);
        chk("overrun_count", count, 16);
        drain();
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Full FIFO: take and pop together
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h20 + i));
        chk("rd_data_full_pop", rd_data, q.pop_front());
        rx_data = 8'h30; rx_rdy = 1'b1; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        q.push_back(8'h30);
        chk("full_take_pop", {rx_rdy_clr, full, overrun, count}, {1'b1, 1'b1, 1'b0, 5'd16});
        cyc();
        rx_rdy = 1'b0;

        // ovr_clr coinciding with a new overrun
        rx_data = 8'hEE; rx_rdy = 1'b1; ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_set_wins", {rx_rdy_clr, overrun, count}, {1'b1, 1'b1, 5'd16});
        cyc();
        rx_rdy = 1'b0;
        drain();

        // Wrap-around with interleaved push/pop
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(8'h40 + i));
            if (i >= 2) read_byte();
        end
        drain();
        chk("wrap_max_count", max_cnt, 3);

`ifdef RX_FIFO_WATERMARK_EN
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h80 + i));
        chk("irq_below", level_irq, 0);
        send_byte(8'h83);
        chk("irq_rise", level_irq, 1);
        read_byte();
        chk("irq_fall", level_irq, 0);
        drain();
        thresh = 5'd0;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'(8'h90 + i));
            chk("irq_disabled", level_irq, 0);
        end
        drain();
`endif

        // Asynchronous reset mid-operation with overrun set and a clr pulse pending
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'hC0 + i));
        send_byte(8'hD0);
        drain();
        for (int i = 0; i < 5; i++) send_byte(8'(8'hB0 + i));
        rx_data = 8'h99; rx_rdy = 1'b1;
        cyc();
        chk("pre_reset_state", {rx_rdy_clr, overrun, count}, {1'b1, 1'b1, 5'd6});
        #4;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {rx_rdy_clr, empty, overrun, count}, {1'b0, 1'b1, 1'b0, 5'd0});
        q.delete();
        m_count = 0;
        rx_data = 8'h3C;
        @(negedge clk_50m);
        rst_n = 1'b1;
        cyc();
        q.push_back(8'h3C);
        m_count = 1;
        chk("post_reset_take", {rx_rdy_clr, count, rd_data}, {1'b1, 5'd1, 8'h3C});
        cyc();
        rx_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receiver. It captures each completed byte from the receiver's data/rdy outputs, acknowledges it with a one-cycle rdy_clr pulse, and stores it in a first-word-fall-through FIFO. The host side then drains the FIFO at its own pace. Overrun, meaning a byte arrives while the FIFO is full, is flagged sticky.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (default 16).

Ports:
clk_50m  input  1  system clock, 50 MHz; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from receiver (receiver data output)
rx_rdy  input  1  receiver byte-ready flag (level, held until cleared)
rx_rdy_clr  output  1  one-cycle pulse to receiver rdy_clr; registered
rd_en  input  1  pop request from consumer
rd_data  output  8  head-of-FIFO byte, valid whenever empty=0 (FWFT)
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
overrun  output  1  sticky: a byte was dropped because FIFO was full
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (rst_n low, asynchronous):
  - rx_rdy_clr=0, count=0, empty=1, full=0, overrun=0.
  - Read and write pointers = 0.
  - rd_data = 0 while empty.
  - Memory contents are not reset.
- Capture condition, evaluated on each clock edge: take = rx_rdy & ~rx_rdy_clr.
  - The guard exists because the receiver deasserts rdy one cycle after rdy_clr. The cycle in which rx_rdy_clr=1 is therefore never a capture cycle.
  - On take: rx_rdy_clr<=1 for exactly one cycle. This happens whether or not the byte is stored.
- Push on take:
  - If not full, or if full and a pop is accepted in the same cycle: mem[wr_ptr]<=rx_data, wr_ptr advances.
  - If full and no pop: byte discarded, overrun<=1, pointers unchanged.
- Pop: accepted when rd_en=1 and empty=0; rd_ptr advances.
  - rd_en while empty is ignored. No pointer change, no error flag.
- rd_data = mem[rd_ptr] (combinational read).
  - A byte pushed at edge N is visible on rd_data after edge N. Latency from rx_rdy high to empty=0 is 1 cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- count is updated each edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - count never exceeds depth and never goes below 0.
- empty = (count==0), full = (count==depth); both are derived from registered count.
- Simultaneous push and pop when empty: the push is stored and the pop is ignored; count becomes 1.
- Overrun flag:
  - ovr_clr=1 clears it.
  - If ovr_clr and a new overrun occur in the same cycle, set wins and overrun=1.
- Receiver re-asserting rdy on the same edge that rdy_clr takes effect: rx_rdy stays high. The byte is captured on the following cycle (take is true again once rx_rdy_clr drops) and is not lost.
- Reset mid-operation: FIFO empties immediately and any pending rx_rdy_clr pulse is aborted. A receiver rdy still high after reset release is captured normally.

Optional Feature:
RX_FIFO_WATERMARK_EN
- Defined:
  - Adds input thresh [DEPTH_LOG2:0] and output level_irq (1 bit, registered, reset 0).
  - level_irq = 1 when the next-state count >= thresh and thresh != 0; it is updated on the same edge as count.
  - thresh=0 disables the interrupt, holding level_irq=0.
- Undefined: thresh and level_irq ports are absent; all other behaviour is identical.

Test Plan:
- Single byte: rx_data=8'hA5, rx_rdy held high until rx_rdy_clr is seen. Required: one rx_rdy_clr pulse, one entry stored, then empty=0, count=1, rd_data=A5. rd_en for one cycle then gives empty=1, count=0.
- Fill and overrun (DEPTH_LOG2=4): push bytes 0x00..0x0F, giving full=1 and count=16. Push 0x10: rx_rdy_clr still pulses, overrun=1, count=16. Drain all: bytes read 0x00..0x0F in order and 0x10 is absent. ovr_clr gives overrun=0.
- Wrap-around: 40 push/pop interleaved bytes with an incrementing pattern. All bytes are read back in order; count never exceeds 3.
- Simultaneous events:
  - Full FIFO, take and rd_en in the same cycle: new byte stored, count stays 16, overrun=0.
  - Empty FIFO, rd_en with take: count=1.
  - ovr_clr with a new overrun: overrun=1.
- Reset mid-operation: 5 entries queued, rst_n pulsed low asynchronously between edges. Outputs go immediately to empty=1, count=0, overrun=0, rx_rdy_clr=0. After release, a fresh byte 0x3C is read back correctly.
- RX_FIFO_WATERMARK_EN with thresh=4: level_irq rises on the edge count reaches 4 and falls on the edge count drops to 3. With thresh=0, level_irq stays 0 through a full fill.
